ahb_arb_2m1s: RTL
=================

AHB_ARB_2M1S -- requirements
Module: ahb_arb_2m1s

Interface
REQ-001 Parameter FIXED_PRIO, default 0, meaning: 0 = round-robin between masters; 1 = M1 always wins a tie.
REQ-002 HCLK  input  1  clock; all state changes on rising edge.
REQ-003 HRESETn  input  1  reset, asynchronous, active-low.
REQ-004 HADDR_Mx, HSIZE_Mx, HTRANS_Mx, HWDATA_Mx, HWRITE_Mx  input  32/3/2/32/1  AHB-Lite master-side request of master x (x = 1, 2).
REQ-005 HRDATA_Mx  output  32  read data to master x; HREADY_Mx  output  1  ready to master x.
REQ-006 HADDR, HSIZE, HTRANS, HWDATA, HWRITE  output  32/3/2/32/1  AHB-Lite slave-side request.
REQ-007 HRDATA  input  32  slave read data; HREADY  input  1  slave ready.

Function
REQ-008 Per master x: hold register {addr, size, write} and flag pend_x; capture when HTRANS_Mx[1]=1 and HREADY_Mx=1; pend_x set.
REQ-009 SEQ and NONSEQ are treated identically; every issued slave transfer is NONSEQ (2'b10); no bursts are propagated.
REQ-010 HREADY_Mx = 1 when pend_x=0; = HREADY when FSM is DATA and owner=x; = 0 otherwise.
REQ-011 HRDATA_Mx = HRDATA, unconditionally.
REQ-012 FSM states: IDLE, ADDR, DATA; owner register (1 bit); last register (1 bit, last-granted master).
REQ-013 IDLE: if pend_1 or pend_2, latch owner per REQ-016 -> ADDR; else stay IDLE. Slave HTRANS = 2'b00.
REQ-014 ADDR: slave HADDR/HSIZE/HWRITE = owner hold register; HTRANS = 2'b10; HREADY=1 -> DATA, last <= owner; HREADY=0 -> stay ADDR, outputs stable.
REQ-015 DATA: HTRANS = 2'b00; HWDATA = HWDATA_M(owner); HREADY=0 -> stay; HREADY=1 -> clear pend_owner (unless REQ-017), then ADDR with new owner if the other master (or owner) is pending, else IDLE.
REQ-016 Arbitration: only one pending -> that master; both pending -> FIXED_PRIO=1: M1; FIXED_PRIO=0: master != last.
REQ-017 Simultaneous completion and new request by the same master (DATA, HREADY=1, HTRANS_Mowner[1]=1): hold register reloaded, pend stays 1; the new request competes in the same arbitration decision.
REQ-018 Outside ADDR, slave HADDR/HSIZE/HWRITE hold the last-driven values (no toggling in IDLE/DATA); HWDATA = HWDATA_M(owner) in all states.
REQ-019 Latency, zero-wait slave, idle arbiter: request accepted cycle t -> IDLE t+1 -> ADDR t+2 -> DATA t+3, HREADY_Mx=1 at t+3; back-to-back alternating masters: one transfer per 2 cycles.
REQ-020 A non-owner pending master sees HREADY_Mx=0 continuously until its own data phase completes; starvation bound under round-robin: one transfer of the other master.

Reset
REQ-021 HRESETn low: FSM=IDLE, pend_1=pend_2=0, owner=0 (M1), last=1 (M2), hold registers=0.
REQ-022 Reset outputs: HTRANS=2'b00, HADDR=0, HSIZE=0, HWRITE=0, HREADY_M1=HREADY_M2=1.
REQ-023 Reset asserted mid-transfer aborts immediately; no pending request survives; first request after release is served normally.

Verification
REQ-024 M1 single read 0x4000_0010, zero-wait slave, HRDATA=0xA5A5_A5A5 -> slave NONSEQ at t+2, HREADY_M1=1 with HRDATA_M1=0xA5A5_A5A5 at t+3.
REQ-025 M1 and M2 request in same cycle, FIXED_PRIO=0, after reset -> M1 issued first, M2 second; repeated simultaneous streams -> strict alternation M1,M2,M1,M2.
REQ-026 Same as REQ-025 with FIXED_PRIO=1 and M1 requesting continuously -> M1 wins every tie; M2 served only when pend_1=0 at decision.
REQ-027 M2 write 0x6000_0004 data 0x1234_5678, slave HREADY low 3 cycles in DATA -> HWDATA=0x1234_5678 stable, HREADY_M2=0 for 3 cycles, then 1 for one cycle; slave address outputs stable throughout.
REQ-028 M1 back-to-back NONSEQ captured on its completion cycle (REQ-017) -> second transfer issued without loss; pend_1 never drops.
REQ-029 HRESETn pulsed low during DATA of M2 -> all outputs at REQ-022 values asynchronously; subsequent M1 request completes in 3 cycles.

Source files
------------

// File: rtl/ahb_arb_2m1s.sv
// rtl/ahb_arb_2m1s.sv - two-master to one-slave AHB-Lite arbiter with request hold registers
module ahb_arb_2m1s #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR_M1,
    input  logic [2:0]  HSIZE_M1,
    input  logic [1:0]  HTRANS_M1,
    input  logic [31:0] HWDATA_M1,
    input  logic        HWRITE_M1,
    output logic [31:0] HRDATA_M1,
    output logic        HREADY_M1,
    input  logic [31:0] HADDR_M2,
    input  logic [2:0]  HSIZE_M2,
    input  logic [1:0]  HTRANS_M2,
    input  logic [31:0] HWDATA_M2,
    input  logic        HWRITE_M2,
    output logic [31:0] HRDATA_M2,
    output logic        HREADY_M2,
    output logic [31:0] HADDR,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    input  logic [31:0] HRDATA,
    input  logic        HREADY
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_owner, w_owner_nxt;
    logic        r_last;
    logic        r_pend1, r_pend2;
    logic [31:0] r_addr1, r_addr2;
    logic [2:0]  r_size1, r_size2;
    logic        r_write1, r_write2;
    logic [31:0] r_haddr;
    logic [2:0]  r_hsize;
    logic        r_hwrite;

    logic        w_cap1, w_cap2, w_done;
    logic        w_pend1_nxt, w_pend2_nxt;
    logic [31:0] w_own_addr;
    logic [2:0]  w_own_size;
    logic        w_own_write;
    logic        w_unused;

    // SEQ/NONSEQ are not distinguished, so only bit 1 of HTRANS matters
    assign w_unused = &{1'b0, HTRANS_M1[0], HTRANS_M2[0]};

    function automatic logic arb(input logic p1, input logic p2, input logic last);
        if (p1 && p2)
            return (FIXED_PRIO != 0) ? 1'b0 : ~last;
        else if (p2)
            return 1'b1;
        else
            return 1'b0;
    endfunction

    assign HREADY_M1 = ~r_pend1 | ((r_state == ST_DATA) & ~r_owner & HREADY);
    assign HREADY_M2 = ~r_pend2 | ((r_state == ST_DATA) &  r_owner & HREADY);
    assign HRDATA_M1 = HRDATA;
    assign HRDATA_M2 = HRDATA;

    assign w_cap1 = HTRANS_M1[1] & HREADY_M1;
    assign w_cap2 = HTRANS_M2[1] & HREADY_M2;
    assign w_done = (r_state == ST_DATA) & HREADY;

    // A capture on the completion cycle keeps pend set with the new request
    assign w_pend1_nxt = w_cap1 | (r_pend1 & ~(w_done & ~r_owner));
    assign w_pend2_nxt = w_cap2 | (r_pend2 & ~(w_done &  r_owner));

    assign w_own_addr  = r_owner ? r_addr2  : r_addr1;
    assign w_own_size  = r_owner ? r_size2  : r_size1;
    assign w_own_write = r_owner ? r_write2 : r_write1;

    assign HTRANS = (r_state == ST_ADDR) ? 2'b10 : 2'b00;
    assign HADDR  = (r_state == ST_ADDR) ? w_own_addr  : r_haddr;
    assign HSIZE  = (r_state == ST_ADDR) ? w_own_size  : r_hsize;
    assign HWRITE = (r_state == ST_ADDR) ? w_own_write : r_hwrite;
    assign HWDATA = r_owner ? HWDATA_M2 : HWDATA_M1;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (r_pend1 || r_pend2) begin
                    w_state_nxt = ST_ADDR;
                    w_owner_nxt = arb(r_pend1, r_pend2, r_last);
                end
            end
            ST_ADDR: begin
                if (HREADY)
                    w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (HREADY) begin
                    if (w_pend1_nxt || w_pend2_nxt) begin
                        w_state_nxt = ST_ADDR;
                        w_owner_nxt = arb(w_pend1_nxt, w_pend2_nxt, r_last);
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= ST_IDLE;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_pend1  <= 1'b0;
            r_pend2  <= 1'b0;
            r_addr1  <= '0;
            r_size1  <= '0;
            r_write1 <= 1'b0;
            r_addr2  <= '0;
            r_size2  <= '0;
            r_write2 <= 1'b0;
            r_haddr  <= '0;
            r_hsize  <= '0;
            r_hwrite <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_pend1 <= w_pend1_nxt;
            r_pend2 <= w_pend2_nxt;
            if (w_cap1) begin
                r_addr1  <= HADDR_M1;
                r_size1  <= HSIZE_M1;
                r_write1 <= HWRITE_M1;
            end
            if (w_cap2) begin
                r_addr2  <= HADDR_M2;
                r_size2  <= HSIZE_M2;
                r_write2 <= HWRITE_M2;
            end
            // Remember the driven address phase so the slave bus stays quiet outside ADDR
            if (r_state == ST_ADDR) begin
                r_haddr  <= w_own_addr;
                r_hsize  <= w_own_size;
                r_hwrite <= w_own_write;
                if (HREADY)
                    r_last <= r_owner;
            end
        end
    end

endmodule
